logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 1..64).
REQ-002 Parameter CNT_W, default 16, width of the transaction counter (legal 4..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B (ignored for NOT).
REQ-009 op  input  3  operation select.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 y  output  WIDTH  result.
REQ-013 zero  output  1  y is all zeros.
REQ-014 ones  output  1  y is all ones.
REQ-015 op_err  output  1  result beat came from a reserved op code.
REQ-016 txn_cnt  output  CNT_W  count of results delivered.

Function
REQ-017 op encoding SHALL be: 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved; all bitwise over WIDTH bits.
REQ-018 Op 7 SHALL give y = 0, zero = 1, ones = 0, op_err = 1; op_err SHALL be 0 for ops 0..6.
REQ-019 Input accepted when in_valid & in_ready; output delivered when out_valid & out_ready.
REQ-020 Two register stages: S1 captures a, b, op; S2 captures y, zero, ones, op_err computed from S1; latency accept-to-out_valid = 2 cycles with no stall.
REQ-021 Each stage advances when it is empty or the next stage advances; S2 advances when empty or out_ready = 1.
REQ-022 in_ready = !S1_valid | S2_advances; combinational from out_ready, no combinational path from in_valid.
REQ-023 Full throughput: with out_ready held 1, one beat accepted and one delivered every cycle.
REQ-024 While out_valid = 1 and out_ready = 0, y, zero, ones, op_err SHALL hold stable; no beat lost or duplicated.
REQ-025 Beats SHALL leave in acceptance order.
REQ-026 txn_cnt increments by 1 on each delivered beat, wraps from 2^CNT_W-1 to 0.
REQ-027 Simultaneous accept and deliver in one cycle SHALL both take effect; pipeline holds at most 2 beats.

Reset
REQ-028 rst asserted SHALL immediately clear S1/S2 valid, y = 0, zero = 0, ones = 0, op_err = 0, txn_cnt = 0, independent of clk.
REQ-029 In-flight beats at reset SHALL be discarded; in_ready = 1 from the first edge after rst deasserts.

Configuration
REQ-030 Macro LOGIC_UNIT_PIPE_PARITY_EN: when defined, add output parity (1 bit, registered in S2, = XOR-reduction of y, 0 in reset, held under stall); when undefined, the port and logic SHALL be absent and all other behaviour unchanged.

Verification
REQ-031 WIDTH=8, op=1, a=8'hF0, b=8'h3C, out_ready=1 -> 2 cycles later out_valid=1, y=8'h30, zero=0, ones=0, txn_cnt=1.
REQ-032 Sweep op 0..7 with a=8'hA5, b=8'h0F back-to-back -> y = 5A, 05, AF, FA, 50, AA, 55, 00 on consecutive cycles; op_err=1 only on last.
REQ-033 Fill with 2 beats, out_ready=0 for 5 cycles -> in_ready=0, y stable at first result; release -> both beats delivered in order, no duplicates.
REQ-034 CNT_W=4, deliver 17 beats -> txn_cnt wraps 15 -> 0 -> 1.
REQ-035 Assert rst mid-stream with 2 beats in flight -> outputs zero asynchronously; after release no stale beat appears.
REQ-036 With LOGIC_UNIT_PIPE_PARITY_EN, op=5, a=8'h07, b=8'h00 -> y=8'h07, parity=1; without macro, build has no parity port.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined bitwise logic unit.
// S1 registers the operands and op code, S2 registers the result and its flags.
// A transaction counter tracks delivered result beats.
// Optional feature: define LOGIC_UNIT_PIPE_PARITY_EN to add a registered
// even-parity output of y.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic             op_err,
   output logic [CNT_W-1:0] txn_cnt
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam logic [2:0] OpNot  = 3'd0;
   localparam logic [2:0] OpAnd  = 3'd1;
   localparam logic [2:0] OpOr   = 3'd2;
   localparam logic [2:0] OpNand = 3'd3;
   localparam logic [2:0] OpNor  = 3'd4;
   localparam logic [2:0] OpXor  = 3'd5;
   localparam logic [2:0] OpXnor = 3'd6;

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;

   // Stage 2 state
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

   logic s1_adv, s2_adv, accept, deliver;

   // Handshake: a stage moves when it is empty or its successor moves.
   always_comb begin
      s2_adv  = !s2_valid_q || out_ready;
      s1_adv  = !s1_valid_q || s2_adv;
      accept  = in_valid && s1_adv;
      deliver = s2_valid_q && out_ready;
   end

   // Next-state for valids and the delivered-beat counter (wraps naturally).
   always_comb begin
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      txn_cnt_d  = deliver ? txn_cnt_q + CNT_W'(1) : txn_cnt_q;
   end

   // Result and flag computation from the S1 operands.
   always_comb begin
      y_d   = '0;
      err_d = 1'b0;
      unique case (op_q)
         OpNot:   y_d = ~a_q;
         OpAnd:   y_d = a_q & b_q;
         OpOr:    y_d = a_q | b_q;
         OpNand:  y_d = ~(a_q & b_q);
         OpNor:   y_d = ~(a_q | b_q);
         OpXor:   y_d = a_q ^ b_q;
         OpXnor:  y_d = ~(a_q ^ b_q);
         default: begin
            y_d   = '0;
            err_d = 1'b1;
         end
      endcase
      zero_d = (y_d == '0);
      ones_d = &y_d;
   end

   // Stage 1 registers: operands captured only on an accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
         end
      end
   end

   // Stage 2 registers: result held stable while stalled by out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         zero_q     <= 1'b0;
         ones_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_adv && s1_valid_q) begin
            y_q    <= y_d;
            zero_q <= zero_d;
            ones_q <= ones_d;
            err_q  <= err_d;
         end
      end
   end

   // Delivered-beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_cnt_q <= '0;
      end else begin
         txn_cnt_q <= txn_cnt_d;
      end
   end

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic parity_q;

   // Parity travels with the S2 result so it stalls identically.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (s2_adv && s1_valid_q) begin
         parity_q <= ^y_d;
      end
   end

   assign parity = parity_q;
`endif

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign ones      = ones_q;
   assign op_err    = err_q;
   assign txn_cnt   = txn_cnt_q;

endmodule
